issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Parametrised, multi-FU reservation station that succeeds the single-entry-write RS used in the current core.
- Accepts one renamed instruction per cycle from dispatch and stores it in the lowest free slot.
- Wakes up pending source operands by snooping NUM_CDB result broadcast buses.
- Each cycle, selects at most one ready entry per functional unit and frees that entry on handshake.

Parameters:
- DEPTH, 16, number of entries (power of two, 4..64)
- NUM_FU, 3, number of functional units / issue ports
- NUM_CDB, 2, number of result broadcast buses snooped
- DATA_W, 32, operand width
- TAG_W, 6, physical register tag width
- ROB_W, 6, ROB index width
- OP_W, 4, ALU control width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of all entries
- alloc_valid  in  1  dispatch presents an instruction
- alloc_ready  out  1  queue can accept (count < DEPTH)
- alloc_op  in  OP_W  ALU control
- alloc_rd  in  TAG_W  destination tag
- alloc_rob  in  ROB_W  ROB index
- alloc_src1_tag, alloc_src2_tag  in  TAG_W  source tags
- alloc_src1_rdy, alloc_src2_rdy  in  1  source value already valid
- alloc_src1_val, alloc_src2_val  in  DATA_W  source values (used when rdy=1)
- alloc_use_imm  in  1  operand 2 comes from immediate
- alloc_imm  in  DATA_W  immediate
- cdb_valid  in  NUM_CDB  broadcast valid per bus
- cdb_tag  in  NUM_CDB*TAG_W  broadcast tags, bus k at [k*TAG_W +: TAG_W]
- cdb_data  in  NUM_CDB*DATA_W  broadcast values
- issue_valid  out  NUM_FU  port k holds a ready instruction
- issue_ready  in  NUM_FU  FU k accepts this cycle
- issue_op  out  NUM_FU*OP_W  flattened per port
- issue_op1, issue_op2  out  NUM_FU*DATA_W  operand 1; operand 2 (imm when use_imm)
- issue_rd  out  NUM_FU*TAG_W
- issue_rob  out  NUM_FU*ROB_W
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

Behaviour:
- Entry fields: valid, op, rd, rob, src1 {tag,rdy,val}, src2 {tag,rdy,val}, fu (0..NUM_FU-1).
- alloc_use_imm=1 stores op2 = imm with src2 rdy forced to 1.
- Reset and flush:
  - Reset clears all valid bits, count=0 and the FU round-robin pointer=0.
  - Out of reset: issue_valid=0, all issue_* buses 0, alloc_ready=1, empty=1.
  - flush takes effect at the edge, has priority over alloc and issue, and resets the pointer.
- Allocation:
  - On an edge with alloc_valid & alloc_ready, write the lowest-index free slot, set valid, and set fu = pointer.
  - The pointer then advances modulo NUM_FU, wrapping from NUM_FU-1 to 0. It does not advance when no alloc occurs.
  - alloc_ready depends only on registered count, not on same-cycle issue.
  - alloc_valid while !alloc_ready is ignored with no state change.
- Wakeup:
  - At each edge, any valid entry source with rdy=0 whose tag equals a valid CDB tag sets rdy=1 and captures that bus's data.
  - If two buses carry the same tag, the lowest bus index wins.
  - Allocation bypass: a non-ready alloc source matching a same-cycle CDB tag is written as rdy=1 with the CDB data.
- Select (combinational):
  - issue_valid[k] = 1 if any valid entry with fu==k has both sources ready.
  - The selected entry is the lowest index among those; issue_* fields come from it.
  - When issue_valid[k]=0, port k fields are 0.
- Issue handshake: on an edge with issue_valid[k] & issue_ready[k], the selected entry's valid bit clears. When issue_valid[k]=1 and issue_ready[k]=0, the outputs hold steady (same entry, unless a lower-index entry becomes ready).
- Latency:
  - An entry allocated at edge t can issue in the cycle after t if its sources were ready.
  - A CDB broadcast in cycle t makes dependents issuable in cycle t+1; there is no same-cycle CDB-to-issue path.
- Count: count_next = count + alloc_fire - popcount(issue fires), all in the same cycle. A full queue with a simultaneous issue still rejects the alloc.
- A freed slot is reusable by an alloc at the next edge.
- Reset asserted mid-operation discards all entries immediately.

Test Plan:
- Reset, then alloc op=4'd2, rd=5, src1/src2 rdy=1, vals 7/9 -> next cycle issue_valid=3'b001, issue_op1=7, issue_op2=9, issue_rd=5; with issue_ready[0]=1, count returns to 0.
- Alloc 3 ready instructions back-to-back -> each lands on ports 0, 1, 2 in turn; the 4th alloc wraps to port 0.
- Alloc with src1 tag=12 not ready, then cdb_valid=2'b10, tag[1]=12, data=32'hDEAD -> next cycle issue_op1=32'hDEAD; no issue in the broadcast cycle.
- Alloc with src2 tag=20 not ready in the same cycle CDB0 broadcasts tag 20, data=3 -> entry issues next cycle with op2=3.
- Fill DEPTH=16 entries with non-ready sources -> alloc_ready=0, count=16; an extra alloc is ignored. Broadcast the tag and issue one entry -> alloc_ready=1 the following cycle.
- Hold issue_ready=0 on a valid port for 5 cycles -> outputs stable, count unchanged. Assert flush with 10 entries -> count=0 and empty=1 next cycle, issue_valid=0.

Source files
------------

// File: rtl/issue_queue.sv
// Multi-FU reservation station: lowest-free-slot alloc, CDB wakeup,
// round-robin FU assignment and per-port lowest-index select.
module issue_queue #(
  parameter int DEPTH   = 16,
  parameter int NUM_FU  = 3,
  parameter int NUM_CDB = 2,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6,
  parameter int ROB_W   = 6,
  parameter int OP_W    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        alloc_valid,
  output logic                        alloc_ready,
  input  logic [OP_W-1:0]             alloc_op,
  input  logic [TAG_W-1:0]            alloc_rd,
  input  logic [ROB_W-1:0]            alloc_rob,
  input  logic [TAG_W-1:0]            alloc_src1_tag,
  input  logic [TAG_W-1:0]            alloc_src2_tag,
  input  logic                        alloc_src1_rdy,
  input  logic                        alloc_src2_rdy,
  input  logic [DATA_W-1:0]           alloc_src1_val,
  input  logic [DATA_W-1:0]           alloc_src2_val,
  input  logic                        alloc_use_imm,
  input  logic [DATA_W-1:0]           alloc_imm,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
  output logic [NUM_FU-1:0]           issue_valid,
  input  logic [NUM_FU-1:0]           issue_ready,
  output logic [NUM_FU*OP_W-1:0]      issue_op,
  output logic [NUM_FU*DATA_W-1:0]    issue_op1,
  output logic [NUM_FU*DATA_W-1:0]    issue_op2,
  output logic [NUM_FU*TAG_W-1:0]     issue_rd,
  output logic [NUM_FU*ROB_W-1:0]     issue_rob,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [DEPTH-1:0]  e_vld;
  logic [DEPTH-1:0]  e_r1;
  logic [DEPTH-1:0]  e_r2;
  logic [OP_W-1:0]   e_op  [DEPTH];
  logic [TAG_W-1:0]  e_rd  [DEPTH];
  logic [ROB_W-1:0]  e_rob [DEPTH];
  logic [TAG_W-1:0]  e_t1  [DEPTH];
  logic [TAG_W-1:0]  e_t2  [DEPTH];
  logic [DATA_W-1:0] e_v1  [DEPTH];
  logic [DATA_W-1:0] e_v2  [DEPTH];
  logic [FU_W-1:0]   e_fu  [DEPTH];

  logic [CNT_W-1:0]  cnt;
  logic [FU_W-1:0]   ptr;

  logic [DEPTH-1:0]  w1_hit;
  logic [DEPTH-1:0]  w2_hit;
  logic [DATA_W-1:0] w1_val [DEPTH];
  logic [DATA_W-1:0] w2_val [DEPTH];
  logic              a1_hit;
  logic              a2_hit;
  logic [DATA_W-1:0] a1_val;
  logic [DATA_W-1:0] a2_val;

  logic [IDX_W-1:0]  free_idx;
  logic [DEPTH-1:0]  set_v;
  logic [DEPTH-1:0]  clr_v;
  logic [DEPTH-1:0]  rdy_e;
  logic [IDX_W-1:0]  sel [NUM_FU];
  logic [NUM_FU-1:0] sel_vld;
  logic [NUM_FU-1:0] fire;
  logic [CNT_W-1:0]  n_iss;
  logic              alloc_fire;

  assign alloc_ready = cnt < CNT_W'(DEPTH);
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign count       = cnt;
  assign empty       = (cnt == '0);
  assign rdy_e       = e_vld & e_r1 & e_r2;

  // Descending bus loop so the lowest-index bus wins on a tag clash.
  always_comb begin
    a1_hit = 1'b0;
    a2_hit = 1'b0;
    a1_val = '0;
    a2_val = '0;
    w1_hit = '0;
    w2_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w1_val[i] = '0;
      w2_val[i] = '0;
    end
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (cdb_valid[k]) begin
        if (cdb_tag[k*TAG_W +: TAG_W] == alloc_src1_tag) begin
          a1_hit = 1'b1;
          a1_val = cdb_data[k*DATA_W +: DATA_W];
        end
        if (cdb_tag[k*TAG_W +: TAG_W] == alloc_src2_tag) begin
          a2_hit = 1'b1;
          a2_val = cdb_data[k*DATA_W +: DATA_W];
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (cdb_tag[k*TAG_W +: TAG_W] == e_t1[i]) begin
            w1_hit[i] = 1'b1;
            w1_val[i] = cdb_data[k*DATA_W +: DATA_W];
          end
          if (cdb_tag[k*TAG_W +: TAG_W] == e_t2[i]) begin
            w2_hit[i] = 1'b1;
            w2_val[i] = cdb_data[k*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!e_vld[i]) free_idx = IDX_W'(i);
    end
    set_v = '0;
    if (alloc_fire) set_v[free_idx] = 1'b1;
  end

  always_comb begin
    sel_vld = '0;
    clr_v   = '0;
    n_iss   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      sel[k] = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (rdy_e[i] && e_fu[i] == FU_W'(k)) begin
          sel_vld[k] = 1'b1;
          sel[k]     = IDX_W'(i);
        end
      end
    end
    fire = sel_vld & issue_ready;
    for (int k = 0; k < NUM_FU; k++) begin
      if (fire[k]) clr_v[sel[k]] = 1'b1;
      n_iss = n_iss + CNT_W'(fire[k]);
    end
  end

  always_comb begin
    issue_valid = sel_vld;
    issue_op    = '0;
    issue_op1   = '0;
    issue_op2   = '0;
    issue_rd    = '0;
    issue_rob   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (sel_vld[k]) begin
        issue_op[k*OP_W +: OP_W]       = e_op[sel[k]];
        issue_op1[k*DATA_W +: DATA_W]  = e_v1[sel[k]];
        issue_op2[k*DATA_W +: DATA_W]  = e_v2[sel[k]];
        issue_rd[k*TAG_W +: TAG_W]     = e_rd[sel[k]];
        issue_rob[k*ROB_W +: ROB_W]    = e_rob[sel[k]];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_vld <= '0;
      cnt   <= '0;
      ptr   <= '0;
    end else if (flush) begin
      e_vld <= '0;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      e_vld <= (e_vld & ~clr_v) | set_v;
      cnt   <= cnt + CNT_W'(alloc_fire) - n_iss;
      if (alloc_fire) begin
        if (ptr == FU_W'(NUM_FU - 1)) ptr <= '0;
        else ptr <= ptr + FU_W'(1);
      end
    end
  end

  // Payload needs no reset: it is only observed through e_vld.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (set_v[i]) begin
        e_op[i]  <= alloc_op;
        e_rd[i]  <= alloc_rd;
        e_rob[i] <= alloc_rob;
        e_fu[i]  <= ptr;
        e_t1[i]  <= alloc_src1_tag;
        e_t2[i]  <= alloc_src2_tag;
        e_r1[i]  <= alloc_src1_rdy | a1_hit;
        e_v1[i]  <= alloc_src1_rdy ? alloc_src1_val : a1_val;
        if (alloc_use_imm) begin
          e_r2[i] <= 1'b1;
          e_v2[i] <= alloc_imm;
        end else begin
          e_r2[i] <= alloc_src2_rdy | a2_hit;
          e_v2[i] <= alloc_src2_rdy ? alloc_src2_val : a2_val;
        end
      end else if (e_vld[i]) begin
        if (!e_r1[i] && w1_hit[i]) begin
          e_r1[i] <= 1'b1;
          e_v1[i] <= w1_val[i];
        end
        if (!e_r2[i] && w2_hit[i]) begin
          e_r2[i] <= 1'b1;
          e_v2[i] <= w2_val[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: alloc, round-robin ports, wakeup,
// bypass, full/backpressure, flush and async reset.
module tb_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [3:0]  alloc_op;
  logic [5:0]  alloc_rd;
  logic [5:0]  alloc_rob;
  logic [5:0]  alloc_src1_tag;
  logic [5:0]  alloc_src2_tag;
  logic        alloc_src1_rdy;
  logic        alloc_src2_rdy;
  logic [31:0] alloc_src1_val;
  logic [31:0] alloc_src2_val;
  logic        alloc_use_imm;
  logic [31:0] alloc_imm;
  logic [1:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic [63:0] cdb_data;
  logic [2:0]  issue_valid;
  logic [2:0]  issue_ready;
  logic [11:0] issue_op;
  logic [95:0] issue_op1;
  logic [95:0] issue_op2;
  logic [17:0] issue_rd;
  logic [17:0] issue_rob;
  logic [4:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;

  issue_queue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_op(alloc_op), .alloc_rd(alloc_rd),
    .alloc_rob(alloc_rob),
    .alloc_src1_tag(alloc_src1_tag),
    .alloc_src2_tag(alloc_src2_tag),
    .alloc_src1_rdy(alloc_src1_rdy),
    .alloc_src2_rdy(alloc_src2_rdy),
    .alloc_src1_val(alloc_src1_val),
    .alloc_src2_val(alloc_src2_val),
    .alloc_use_imm(alloc_use_imm), .alloc_imm(alloc_imm),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_op1(issue_op1),
    .issue_op2(issue_op2), .issue_rd(issue_rd),
    .issue_rob(issue_rob), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] op, input logic [5:0] rd,
                     input logic [5:0] t1, input logic r1,
                     input logic [31:0] v1,
                     input logic [5:0] t2, input logic r2,
                     input logic [31:0] v2);
    alloc_valid    = 1'b1;
    alloc_op       = op;
    alloc_rd       = rd;
    alloc_rob      = rd;
    alloc_src1_tag = t1;
    alloc_src1_rdy = r1;
    alloc_src1_val = v1;
    alloc_src2_tag = t2;
    alloc_src2_rdy = r2;
    alloc_src2_val = v2;
    alloc_use_imm  = 1'b0;
    alloc_imm      = '0;
  endtask

  function automatic logic [31:0] op1(input int k);
    return issue_op1[k*32 +: 32];
  endfunction
  function automatic logic [31:0] op2(input int k);
    return issue_op2[k*32 +: 32];
  endfunction
  function automatic logic [5:0] rd(input int k);
    return issue_rd[k*6 +: 6];
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; alloc_valid = 1'b0;
    alloc_op = '0; alloc_rd = '0; alloc_rob = '0;
    alloc_src1_tag = '0; alloc_src2_tag = '0;
    alloc_src1_rdy = 1'b0; alloc_src2_rdy = 1'b0;
    alloc_src1_val = '0; alloc_src2_val = '0;
    alloc_use_imm = 1'b0; alloc_imm = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    issue_ready = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_ivalid", 64'(issue_valid), 0);
    chk("rst_buses", 64'(|{issue_op, issue_op1,
        issue_op2, issue_rd, issue_rob}), 0);
    chk("rst_ready", 64'(alloc_ready), 1);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_count", 64'(count), 0);

    // single ready alloc issues next cycle on port 0
    put(4'd2, 6'd5, 6'd0, 1'b1, 32'd7, 6'd0, 1'b1, 32'd9);
    tick();
    alloc_valid = 1'b0;
    chk("t1_ivalid", 64'(issue_valid), 64'b001);
    chk("t1_op1", 64'(op1(0)), 7);
    chk("t1_op2", 64'(op2(0)), 9);
    chk("t1_rd", 64'(rd(0)), 5);
    chk("t1_op", 64'(issue_op[3:0]), 2);
    chk("t1_rob", 64'(issue_rob[5:0]), 5);
    chk("t1_count", 64'(count), 1);
    issue_ready = 3'b001;
    tick();
    issue_ready = '0;
    chk("t1_count0", 64'(count), 0);
    chk("t1_empty", 64'(empty), 1);
    chk("t1_ivalid0", 64'(issue_valid), 0);
    flush = 1'b1; tick(); flush = 1'b0;

    // round robin over three ports, fourth wraps to port 0
    put(4'd1, 6'd10, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1);
    tick();
    chk("rr_lat", 64'(issue_valid), 64'b001);
    put(4'd1, 6'd11, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1);
    tick();
    put(4'd1, 6'd12, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1);
    tick();
    put(4'd1, 6'd13, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1);
    tick();
    alloc_valid = 1'b0;
    chk("rr_ivalid", 64'(issue_valid), 64'b111);
    chk("rr_p0", 64'(rd(0)), 10);
    chk("rr_p1", 64'(rd(1)), 11);
    chk("rr_p2", 64'(rd(2)), 12);
    chk("rr_count", 64'(count), 4);
    issue_ready = 3'b001;
    tick();
    chk("rr_wrap", 64'(rd(0)), 13);
    chk("rr_count3", 64'(count), 3);
    issue_ready = 3'b111;
    tick();
    issue_ready = '0;
    chk("rr_count0", 64'(count), 0);
    flush = 1'b1; tick(); flush = 1'b0;

    // wakeup from bus 1, no same-cycle issue
    put(4'd3, 6'd20, 6'd12, 1'b0, 32'd0, 6'd0, 1'b1, 32'd1);
    tick();
    alloc_valid = 1'b0;
    chk("wk_wait", 64'(issue_valid), 0);
    cdb_valid = 2'b10;
    cdb_tag   = {6'd12, 6'd0};
    cdb_data  = {32'hDEAD, 32'h0};
    #1;
    chk("wk_nobypass", 64'(issue_valid), 0);
    tick();
    cdb_valid = '0;
    chk("wk_ivalid", 64'(issue_valid), 64'b001);
    chk("wk_op1", 64'(op1(0)), 64'hDEAD);
    chk("wk_op2", 64'(op2(0)), 1);
    issue_ready = 3'b001; tick(); issue_ready = '0;

    // same tag on both buses: bus 0 wins
    put(4'd3, 6'd21, 6'd7, 1'b0, 32'd0, 6'd0, 1'b1, 32'd2);
    tick();
    alloc_valid = 1'b0;
    cdb_valid = 2'b11;
    cdb_tag   = {6'd7, 6'd7};
    cdb_data  = {32'hBBBB, 32'hAAAA};
    tick();
    cdb_valid = '0;
    chk("prio_ivalid", 64'(issue_valid), 64'b010);
    chk("prio_op1", 64'(op1(1)), 64'hAAAA);
    issue_ready = 3'b010; tick(); issue_ready = '0;

    // alloc bypass from same-cycle broadcast
    put(4'd5, 6'd22, 6'd0, 1'b1, 32'd5, 6'd20, 1'b0, 32'd0);
    cdb_valid = 2'b01;
    cdb_tag   = {6'd0, 6'd20};
    cdb_data  = {32'h0, 32'd3};
    tick();
    alloc_valid = 1'b0;
    cdb_valid = '0;
    chk("byp_ivalid", 64'(issue_valid), 64'b100);
    chk("byp_op1", 64'(op1(2)), 5);
    chk("byp_op2", 64'(op2(2)), 3);

    // immediate forces operand 2 ready
    put(4'd6, 6'd23, 6'd0, 1'b1, 32'd8, 6'd33, 1'b0, 32'd0);
    alloc_use_imm = 1'b1;
    alloc_imm = 32'h123;
    tick();
    alloc_valid = 1'b0;
    alloc_use_imm = 1'b0;
    chk("imm_ivalid", 64'(issue_valid), 64'b101);
    chk("imm_op2", 64'(op2(0)), 64'h123);
    chk("imm_rd", 64'(rd(0)), 23);
    chk("imm_count", 64'(count), 2);
    issue_ready = 3'b111; tick(); issue_ready = '0;
    chk("imm_count0", 64'(count), 0);
    flush = 1'b1; tick(); flush = 1'b0;

    // fill with waiting entries
    for (int i = 0; i < 16; i++) begin
      put(4'd1, 6'(i), 6'd40, 1'b0, 32'd0, 6'd0, 1'b1, 32'(i));
      tick();
    end
    alloc_valid = 1'b0;
    chk("full_count", 64'(count), 16);
    chk("full_ready", 64'(alloc_ready), 0);
    chk("full_ivalid", 64'(issue_valid), 0);
    put(4'd1, 6'd63, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0);
    tick();
    alloc_valid = 1'b0;
    chk("full_ignore", 64'(count), 16);
    chk("full_ign_iv", 64'(issue_valid), 0);
    cdb_valid = 2'b01;
    cdb_tag   = {6'd0, 6'd40};
    cdb_data  = {32'h0, 32'h55};
    tick();
    cdb_valid = '0;
    chk("full_wake", 64'(issue_valid), 64'b111);
    chk("full_p0", 64'(rd(0)), 0);
    chk("full_p1", 64'(rd(1)), 1);
    chk("full_p2", 64'(rd(2)), 2);
    chk("full_op1", 64'(op1(1)), 64'h55);
    put(4'd1, 6'd63, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0);
    issue_ready = 3'b001;
    tick();
    alloc_valid = 1'b0;
    issue_ready = '0;
    chk("full_rej_cnt", 64'(count), 15);
    chk("full_rdy_back", 64'(alloc_ready), 1);
    chk("full_next_p0", 64'(rd(0)), 3);
    put(4'd1, 6'd50, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0);
    tick();
    alloc_valid = 1'b0;
    chk("reuse_count", 64'(count), 16);
    chk("reuse_p1", 64'(rd(1)), 50);

    // backpressure keeps port outputs steady
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("hold_rd%0d", c), 64'(rd(0)), 3);
      chk($sformatf("hold_cnt%0d", c), 64'(count), 16);
    end
    issue_ready = 3'b111;
    tick();
    tick();
    issue_ready = '0;
    chk("pre_flush_cnt", 64'(count), 10);
    flush = 1'b1;
    put(4'd1, 6'd44, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0);
    tick();
    flush = 1'b0;
    alloc_valid = 1'b0;
    chk("flush_count", 64'(count), 0);
    chk("flush_empty", 64'(empty), 1);
    chk("flush_ivalid", 64'(issue_valid), 0);
    chk("flush_ready", 64'(alloc_ready), 1);

    // asynchronous reset mid-run
    put(4'd1, 6'd30, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0);
    tick();
    put(4'd1, 6'd31, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0);
    tick();
    alloc_valid = 1'b0;
    chk("ar_count", 64'(count), 2);
    #2 reset = 1'b1;
    #1;
    chk("ar_count0", 64'(count), 0);
    chk("ar_ivalid", 64'(issue_valid), 0);
    chk("ar_empty", 64'(empty), 1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("ar_after", 64'(issue_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
